uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel receive stage for the UART path. It oversamples the asynchronous `rx` pin, decodes 8N1 frames (LSB first), and presents each good byte as a one-cycle `recv_ok` pulse with `recv_data`. It sits directly upstream of the UART controller's receive FIFO, driving its `recv_data`, `recv_ok` and `recv_waiting` inputs and taking `reset` from the controller's `recv_reset`.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (N). N ≥ 4 is required.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous serial line; idles high.
- `recv_data`  out  8  last correctly framed byte.
- `recv_ok`  out  1  one-cycle pulse when `recv_data` is updated.
- `recv_waiting`  out  1  high while in IDLE, waiting for a start bit.
- `framing_error`  out  1  one-cycle pulse when a stop bit is sampled low.

## Operation
- **Synchronizer:** `rx` passes through 2 flops to form `rx_s`. Both flops reset to 1. Only `rx_s` is used internally.
- **Constants:** H = N/2 (integer division). The counter is $clog2(N) bits wide. The bit index is 3 bits.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:**
  - `rx_s`==0 → START, counter cleared.
  - Otherwise stay in IDLE.
- **START:** counts H cycles, then samples `rx_s` (mid start bit).
  - Sample 0 → DATA, counter and bit index cleared.
  - Sample 1 → IDLE (glitch rejected, nothing reported).
- **DATA:** every N cycles, samples `rx_s` into shift register bit [index], LSB first.
  - After bit 7 → STOP, counter cleared.
- **STOP:** after N cycles, samples `rx_s`.
  - Sample 1: `recv_data` ← shift register, `recv_ok` pulses, state → IDLE.
    - IDLE is entered at mid stop bit so a new start edge can be caught immediately.
  - Sample 0: `framing_error` pulses, `recv_data` is unchanged, no `recv_ok`, state → WAIT_HIGH.
- **WAIT_HIGH:** stays until `rx_s`==1, then → IDLE.
  - A held-low line (break) therefore yields exactly one `framing_error` and no bytes.
- **Outputs:**
  - `recv_waiting` = (state==IDLE).
  - `recv_data` holds its value until the next good frame.
  - The downstream consumer has no backpressure; it must accept `recv_ok` in the cycle it is asserted.
- **Reset** (mid-frame included): state → IDLE, partial byte discarded, no `recv_ok` or `framing_error` generated.

## Timing
- **Reset values:**
  - `recv_data` = 0x00.
  - `recv_ok` = 0.
  - `framing_error` = 0.
  - `recv_waiting` = 1.
  - State = IDLE, synchronizer = 1s.
- **Pin to `rx_s`:** 2 cycles.
- **Sample points** (cycle T = first IDLE cycle seeing `rx_s`==0):
  - Start bit: T+H.
  - Data bit k: T+H+(k+1)·N.
  - Stop bit: T+H+9N.
- **Result:** `recv_ok` / `framing_error` are registered and high exactly in cycle T+H+9N+1, for one cycle.
- **Return to waiting:** `recv_waiting` goes high in the same cycle as the `recv_ok` pulse.
- **Bit timing:** the counter restarts at each sample, so no cumulative drift inside the controller. Tolerates ±4% baud mismatch at N ≥ 16.
- **Back-to-back frames:** a start bit directly following the stop bit is received with no lost byte.
- `recv_ok` and `framing_error` are never high in the same cycle.

## Test plan
- **Single byte:** N=16, send 0x55 with ideal timing → `recv_ok` high for exactly 1 cycle, at 2+8+144+1 = 155 cycles after the `rx` falling edge, with `recv_data`=0x55 and `framing_error`=0.
- **Back-to-back:** 0xA5, 0x3C, 0x00, 0xFF with no idle gap, N=16 → four `recv_ok` pulses 160 cycles apart, data in order. Repeat with a bit period of 15 and of 17 clocks → same bytes.
- **Glitch rejection:** `rx` low for 3 cycles, then high, N=16 → no `recv_ok` or `framing_error`. `recv_waiting` returns to 1 within 2+8+1 cycles of the glitch.
- **Framing error:** receive 0x12 OK, then send 0xFF with stop bit 0 → `framing_error` pulses once at the stop sample +1, no `recv_ok`, `recv_data` stays 0x12.
- **Break:** hold `rx` low for 40 bit times, release, then send 0x7E → exactly one `framing_error`, `recv_waiting`=0 until the line rises, then one `recv_ok` with 0x7E.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 4 of 0xC3 → no `recv_ok`. `recv_data`=0x00 and `recv_waiting`=1 in the cycle after reset. A following 0x81 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronizes rx, samples mid-bit with a restarting
// counter, and reports each good byte with a one-cycle recv_ok pulse.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] recv_data,
    output logic       recv_ok,
    output logic       recv_waiting,
    output logic       framing_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic [7:0]       data_next;
    logic             ok_next, fe_next;
    logic             rx_meta, rx_s;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            recv_data     <= 8'h00;
            recv_ok       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bit_idx       <= bit_idx_next;
            recv_data     <= data_next;
            recv_ok       <= ok_next;
            framing_error <= fe_next;
        end
    end

    // NOTE: the shift register carries no reset; every bit is rewritten
    // during DATA before STOP can copy it out.
    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = recv_data;
        ok_next      = 1'b0;
        fe_next      = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = rx_s;
                    bit_idx_next        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift;
                        ok_next    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign recv_waiting = (state == IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: three instances (N=16, 15, 17) fed by a
// bit-banging task; a negedge monitor logs every recv_ok / framing_error pulse.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_w   [3];
    logic [7:0] data_w [3];
    logic       ok_w   [3];
    logic       wait_w [3];
    logic       fe_w   [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int         ok_cnt [3];
    int         ok_cyc [3][16];
    logic [7:0] ok_dat [3][16];
    int         fe_cnt [3];
    int         fe_cyc [3];
    int         both_cnt = 0;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(16)) u_dut16 (
        .clk(clk), .reset(reset), .rx(rx_w[0]), .recv_data(data_w[0]),
        .recv_ok(ok_w[0]), .recv_waiting(wait_w[0]), .framing_error(fe_w[0]));
    uart_receiver #(.CLKS_PER_BIT(15)) u_dut15 (
        .clk(clk), .reset(reset), .rx(rx_w[1]), .recv_data(data_w[1]),
        .recv_ok(ok_w[1]), .recv_waiting(wait_w[1]), .framing_error(fe_w[1]));
    uart_receiver #(.CLKS_PER_BIT(17)) u_dut17 (
        .clk(clk), .reset(reset), .rx(rx_w[2]), .recv_data(data_w[2]),
        .recv_ok(ok_w[2]), .recv_waiting(wait_w[2]), .framing_error(fe_w[2]));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ok_w[i] === 1'b1) begin
                ok_cyc[i][ok_cnt[i] % 16] = cyc;
                ok_dat[i][ok_cnt[i] % 16] = data_w[i];
                ok_cnt[i]++;
            end
            if (fe_w[i] === 1'b1) begin
                fe_cyc[i] = cyc;
                fe_cnt[i]++;
            end
            if (ok_w[i] === 1'b1 && fe_w[i] === 1'b1) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns the cycle the start bit was driven.
    task automatic send_frame(input int inst, input logic [7:0] b, input int period,
                              input logic stop_bit, output int start_cyc);
        logic [9:0] bits;
        bits      = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_w[inst] = bits[i];
            idle(period);
        end
    endtask

    // Pin-to-result latency: 2 sync + H + 9N + 1 register.
    function automatic int latency(input int n);
        return 2 + n / 2 + 9 * n + 1;
    endfunction

    int         s0, s1, g, b, base_ok, base_fe;
    int         starts [4];
    logic [7:0] b2b    [4];
    logic [9:0] frame;
    int         periods [3];

    initial begin
        b2b     = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        periods = '{16, 15, 17};
        for (int i = 0; i < 3; i++) rx_w[i] = 1'b1;
        reset = 1'b1;
        idle(3);

        check("reset_data",    32'(data_w[0]), 32'h00);
        check("reset_ok",      32'(ok_w[0]),   32'h0);
        check("reset_fe",      32'(fe_w[0]),   32'h0);
        check("reset_waiting", 32'(wait_w[0]), 32'h1);
        reset = 1'b0;
        idle(5);

        // Single byte, ideal timing.
        base_ok = ok_cnt[0];
        send_frame(0, 8'h55, 16, 1'b1, s0);
        idle(5);
        check("single_count",   32'(ok_cnt[0] - base_ok), 32'd1);
        check("single_cycle",   32'(ok_cyc[0][base_ok % 16] - s0), 32'd155);
        check("single_data",    32'(ok_dat[0][base_ok % 16]), 32'h55);
        check("single_fe",      32'(fe_cnt[0]), 32'd0);
        check("single_waiting", 32'(wait_w[0]), 32'h1);

        // Back-to-back frames on each bit period.
        for (int inst = 0; inst < 3; inst++) begin
            base_ok = ok_cnt[inst];
            for (int k = 0; k < 4; k++) send_frame(inst, b2b[k], periods[inst], 1'b1, starts[k]);
            idle(10);
            check($sformatf("b2b%0d_count", periods[inst]), 32'(ok_cnt[inst] - base_ok), 32'd4);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("b2b%0d_data%0d", periods[inst], k),
                      32'(ok_dat[inst][(base_ok + k) % 16]), 32'(b2b[k]));
                check($sformatf("b2b%0d_cycle%0d", periods[inst], k),
                      32'(ok_cyc[inst][(base_ok + k) % 16] - starts[k]), 32'(latency(periods[inst])));
            end
            check($sformatf("b2b%0d_fe", periods[inst]), 32'(fe_cnt[inst]), 32'd0);
        end

        // Glitch: 3 low cycles must be rejected at the start-bit sample.
        base_ok = ok_cnt[0];
        g = cyc;
        rx_w[0] = 1'b0;
        idle(3);
        rx_w[0] = 1'b1;
        idle(1);
        check("glitch_started", 32'(wait_w[0]), 32'h0);
        idle(g + 11 - cyc);
        check("glitch_rewait", 32'(wait_w[0]), 32'h1);
        idle(200);
        check("glitch_no_ok", 32'(ok_cnt[0] - base_ok), 32'd0);
        check("glitch_no_fe", 32'(fe_cnt[0]), 32'd0);

        // Framing error after a good byte.
        base_ok = ok_cnt[0];
        send_frame(0, 8'h12, 16, 1'b1, s0);
        send_frame(0, 8'hFF, 16, 1'b0, s1);
        rx_w[0] = 1'b1;
        idle(20);
        check("frame_ok_count", 32'(ok_cnt[0] - base_ok), 32'd1);
        check("frame_good",     32'(ok_dat[0][base_ok % 16]), 32'h12);
        check("frame_fe_count", 32'(fe_cnt[0]), 32'd1);
        check("frame_fe_cycle", 32'(fe_cyc[0] - s1), 32'd155);
        check("frame_data",     32'(data_w[0]), 32'h12);

        // Break: 40 bit times low, one framing error, then a good byte.
        base_ok = ok_cnt[0];
        base_fe = fe_cnt[0];
        b = cyc;
        rx_w[0] = 1'b0;
        idle(639);
        check("break_waiting_low", 32'(wait_w[0]), 32'h0);
        check("break_fe_count",    32'(fe_cnt[0] - base_fe), 32'd1);
        check("break_fe_cycle",    32'(fe_cyc[0] - b), 32'd155);
        idle(1);
        rx_w[0] = 1'b1;
        idle(20);
        check("break_waiting_high", 32'(wait_w[0]), 32'h1);
        send_frame(0, 8'h7E, 16, 1'b1, s0);
        idle(5);
        check("break_ok_count", 32'(ok_cnt[0] - base_ok), 32'd1);
        check("break_data",     32'(ok_dat[0][base_ok % 16]), 32'h7E);
        check("break_fe_total", 32'(fe_cnt[0] - base_fe), 32'd1);

        // Reset in the middle of data bit 4 of 0xC3.
        base_ok = ok_cnt[0];
        base_fe = fe_cnt[0];
        frame   = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_w[0] = frame[i];
            idle(16);
        end
        rx_w[0] = frame[5];
        idle(8);
        reset   = 1'b1;
        rx_w[0] = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rst_data",    32'(data_w[0]), 32'h00);
        check("rst_waiting", 32'(wait_w[0]), 32'h1);
        idle(200);
        check("rst_no_ok", 32'(ok_cnt[0] - base_ok), 32'd0);
        check("rst_no_fe", 32'(fe_cnt[0] - base_fe), 32'd0);
        send_frame(0, 8'h81, 16, 1'b1, s0);
        idle(5);
        check("rst_ok_count", 32'(ok_cnt[0] - base_ok), 32'd1);
        check("rst_next",     32'(ok_dat[0][base_ok % 16]), 32'h81);
        check("rst_cycle",    32'(ok_cyc[0][base_ok % 16] - s0), 32'd155);

        check("ok_fe_overlap", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
